// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller between EX and the iterative divider.
// Launches divides, stalls EX, buffers the result, handles flushes.
module div_issue_ctrl #(
  parameter bit BYPASS_ZERO = 1'b1,
  parameter int TIMEOUT     = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_sign,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        stall_o,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     res_hi_q, res_hi_d;
  logic [31:0]     res_lo_q, res_lo_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            sign_q, sign_d;

  logic accept;
  logic zero_b;
  logic tmo;

  assign accept = req_valid & ~flush;
  assign zero_b = (req_b == 32'd0);
  // >= so a timeout that lands while flushing is still caught in DRAIN
  assign tmo    = (cnt_q >= CW'(TIMEOUT - 1));

  // State, watchdog, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
    end
  end

  // Next state; flush has priority over completion and consumption
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = req_a;
          b_d    = req_b;
          sign_d = req_sign;
          if (BYPASS_ZERO && zero_b) begin
            state_d  = S_DONE;
            res_hi_d = req_a;
            res_lo_d = 32'hFFFF_FFFF;
          end else begin
            state_d = S_LAUNCH;
            cnt_d   = '0;
          end
        end
      end
      S_LAUNCH: begin
        if (flush) begin
          state_d = div_done ? S_IDLE : S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (flush) begin
          state_d = div_done ? S_IDLE : S_DRAIN;
        end else if (div_done) begin
          state_d  = S_DONE;
          res_hi_d = div_result[63:32];
          res_lo_d = div_result[31:0];
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_done) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || !pipe_hold) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    div_start = (state_q == S_LAUNCH);
    res_valid = (state_q == S_DONE) & ~pipe_hold & ~flush;
    stall_o   = accept & ~((state_q == S_DONE) & ~pipe_hold);
  end

  assign res_hi      = res_hi_q;
  assign res_lo      = res_lo_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_sign    = sign_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model.
// Inputs change 2 time units after posedge; outputs sampled 1 later.
module tb_div_issue_ctrl;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_sign = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        pipe_hold = 1'b0;
  logic        stall_o;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic        div_done = 1'b0;
  logic [63:0] div_result;
  logic        err_timeout;

  div_issue_ctrl #(.BYPASS_ZERO(1'b1), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sign(req_sign),
    .req_a(req_a), .req_b(req_b),
    .flush(flush), .pipe_hold(pipe_hold),
    .stall_o(stall_o), .res_valid(res_valid),
    .res_hi(res_hi), .res_lo(res_lo),
    .div_start(div_start), .div_a(div_a),
    .div_b(div_b), .div_sign(div_sign),
    .div_done(div_done), .div_result(div_result),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int n_start = 0;
  int n_res = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (div_start) n_start <= n_start + 1;
    if (res_valid) n_res <= n_res + 1;
  end

  // Divider model: done pulse LAT cycles after the start cycle
  logic        no_done = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;
  assign div_result = m_res;

  function automatic logic [63:0] mdiv(input logic s,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (rst) begin
      m_cnt <= 0;
    end else if (div_start && !no_done) begin
      m_cnt <= LAT - 1;
      m_res <= mdiv(div_sign, div_a, div_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) div_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Issue one request and follow it until res_valid (bounded)
  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int hold,
                       output int start_at, output int done_at,
                       output int res_at, output int stall_low,
                       output int hold_bad, output int start_abs,
                       output int res_abs, output logic [31:0] lo,
                       output logic [31:0] hi);
    logic [63:0] hv;
    start_at = -1; done_at = -1; res_at = -1;
    stall_low = 0; hold_bad = 0;
    start_abs = -1; res_abs = -1;
    lo = '0; hi = '0; hv = '0;
    req_valid = 1'b1; req_sign = s;
    req_a = a; req_b = b; pipe_hold = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (k > 0) begin
        cyc();
        pipe_hold = (done_at >= 0) && (k <= done_at + hold);
      end
      #1;
      if (div_start && start_at < 0) begin
        start_at = k;
        start_abs = cyc_n;
      end
      if (div_done && done_at < 0) done_at = k;
      if (res_valid) begin
        res_at = k;
        res_abs = cyc_n;
        lo = res_lo;
        hi = res_hi;
        pipe_hold = 1'b0;
        break;
      end
      if (!stall_o) stall_low++;
      if (pipe_hold) begin
        if (k == done_at + 1) hv = {res_hi, res_lo};
        else if ({res_hi, res_lo} !== hv) hold_bad++;
      end
    end
  endtask

  int st, dn, rs, sl, hb, sa, ra, sa2, ra2, bs, br, bad, resc;
  logic [31:0] lo, hi;

  initial begin
    cyc();
    cyc();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_res", {res_hi, res_lo}, 0);
    chk("rst_ops", {div_sign, div_a, div_b}, 0);
    chk("rst_stall", stall_o, 0);
    rst = 1'b0;
    cyc();

    // Signed -7 / 2
    bs = n_start; br = n_res;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 0,
          st, dn, rs, sl, hb, sa, ra, lo, hi);
    chk("sdiv_ops", {div_sign, div_a, div_b}, {1'b1, 32'hFFFF_FFF9, 32'd2});
    chk("sdiv_stall_o", stall_o, 0);
    chk("sdiv_start_at", st, 1);
    chk("sdiv_res_at", rs, dn + 1);
    chk("sdiv_stall_low", sl, 0);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);
    cyc();
    req_valid = 1'b0;
    chk("sdiv_n_start", n_start - bs, 1);
    chk("sdiv_n_res", n_res - br, 1);
    cyc();

    // Divide by zero bypass
    bs = n_start;
    issue(1'b0, 32'd100, 32'd0, 0,
          st, dn, rs, sl, hb, sa, ra, lo, hi);
    chk("bz_res_at", rs, 1);
    chk("bz_no_start", st, -1);
    chk("bz_hi", hi, 32'd100);
    chk("bz_lo", lo, 32'hFFFF_FFFF);
    cyc();
    req_valid = 1'b0;
    chk("bz_n_start", n_start - bs, 0);
    cyc();

    // 100 / 7 with pipe_hold for 5 cycles after done
    issue(1'b0, 32'd100, 32'd7, 5,
          st, dn, rs, sl, hb, sa, ra, lo, hi);
    chk("hold_res_at", rs, dn + 6);
    chk("hold_stall_low", sl, 0);
    chk("hold_stable", hb, 0);
    chk("hold_lo", lo, 32'd14);
    chk("hold_hi", hi, 32'd2);
    cyc();
    req_valid = 1'b0;
    cyc();

    // Flush 10 cycles into RUN, then 9 / 3 right behind it
    bs = n_start; br = n_res;
    req_valid = 1'b1; req_sign = 1'b0;
    req_a = 32'd50; req_b = 32'd5;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 12) flush = 1'b1;
    end
    #1;
    chk("fl_stall_o", stall_o, 0);
    cyc();
    flush = 1'b0;
    issue(1'b0, 32'd9, 32'd3, 0,
          st, dn, rs, sl, hb, sa, ra, lo, hi);
    chk("fl_old_done_seen", dn >= 0, 1);
    chk("fl_new_start", st, dn + 2);
    chk("fl_stall_low", sl, 0);
    chk("fl_lo", lo, 32'd3);
    chk("fl_hi", hi, 32'd0);
    cyc();
    req_valid = 1'b0;
    chk("fl_n_start", n_start - bs, 2);
    chk("fl_n_res", n_res - br, 1);
    cyc();

    // Back-to-back 20/4 then 21/4
    bs = n_start; br = n_res;
    issue(1'b0, 32'd20, 32'd4, 0,
          st, dn, rs, sl, hb, sa, ra, lo, hi);
    chk("b2b1_lo", lo, 32'd5);
    chk("b2b1_hi", hi, 32'd0);
    cyc();
    issue(1'b0, 32'd21, 32'd4, 0,
          st, dn, rs, sl, hb, sa2, ra2, lo, hi);
    chk("b2b2_lo", lo, 32'd5);
    chk("b2b2_hi", hi, 32'd1);
    chk("b2b_start_gap", sa2 - ra, 2);
    cyc();
    req_valid = 1'b0;
    chk("b2b_n_start", n_start - bs, 2);
    chk("b2b_n_res", n_res - br, 2);
    cyc();

    // Watchdog: divider never completes
    no_done = 1'b1;
    bad = 0; resc = 0;
    req_valid = 1'b1; req_sign = 1'b0;
    req_a = 32'd1; req_b = 32'd1;
    for (int k = 1; k <= 41; k++) begin
      cyc();
      #1;
      if (err_timeout) bad++;
      if (res_valid) resc++;
    end
    chk("tmo_early", bad, 0);
    cyc();
    req_valid = 1'b0;
    #1;
    chk("tmo_err", err_timeout, 1);
    chk("tmo_res", resc + int'(res_valid), 0);
    chk("tmo_idle_stall", stall_o, 0);
    cyc();
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd0;
    cyc();
    req_valid = 1'b0;
    #1;
    chk("tmo_idle_bz", {res_valid, res_hi}, {1'b1, 32'd7});
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("tmo_rst_clear", err_timeout, 0);
    no_done = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencing controller between the EX stage and the iterative radix-2 divider (start/done interface) of the CPU core. It accepts DIV/DIVU requests and launches the divider with latched operands. It holds the pipeline with a stall while the divide runs, buffers the 64-bit result until the pipeline can take it, and handles exception flushes. Divide-by-zero is short-circuited without using the divider.

Parameters:
BYPASS_ZERO, 1, 1: b==0 completes in controller with fixed result; 0: sent to divider
TIMEOUT, 40, max cycles in RUN/DRAIN before watchdog abort (must exceed divider latency, 34)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  DIV/DIVU in EX; held high until stall_o drops or flush
req_sign  in  1  1 = signed (DIV)
req_a  in  32  dividend
req_b  in  32  divisor
flush  in  1  exception/ERET flush of EX
pipe_hold  in  1  downstream stalled; result must not be consumed
stall_o  out  1  stall EX and earlier stages
res_valid  out  1  HI/LO write-enable pulse; result consumed this cycle
res_hi  out  32  remainder
res_lo  out  32  quotient
div_start  out  1  one-cycle launch pulse to divider
div_a  out  32  latched dividend
div_b  out  32  latched divisor
div_sign  out  1  latched sign
div_done  in  1  divider completion pulse
div_result  in  64  {remainder, quotient}, valid with div_done
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state IDLE; div_start, res_valid, err_timeout = 0; res_hi, res_lo, div_a, div_b, div_sign = 0; timeout counter = 0. Reset mid-divide forces IDLE. A div_done arriving after reset is ignored.
- States: IDLE, LAUNCH, RUN, DONE, DRAIN.
- IDLE: on req_valid & !flush, latch req_a, req_b, req_sign into div_a, div_b, div_sign.
  - If BYPASS_ZERO and req_b==0: go to DONE with res_hi=req_a, res_lo=32'hFFFFFFFF.
  - Otherwise: go to LAUNCH.
  - On req_valid & flush: no accept.
- LAUNCH: div_start=1 for exactly this cycle, then go to RUN.
- RUN: on div_done, capture res_hi=div_result[63:32] and res_lo=div_result[31:0], then go to DONE.
- DONE: res_valid = !pipe_hold & !flush. When res_valid is high, go to IDLE. While pipe_hold is high, hold the result and stay in DONE.
- Flush:
  - In LAUNCH or RUN: go to DRAIN. If div_done occurs in the same cycle, go directly to IDLE and discard the result.
  - In DONE: go to IDLE with no res_valid.
  - flush wins over div_done and over consumption.
- DRAIN: ignore the operands. On div_done, discard the result and go to IDLE. div_start is never asserted in DRAIN.
- stall_o (combinational) = req_valid & !flush & !(state==DONE & !pipe_hold). In DRAIN, a new req_valid stalls until IDLE.
- Minimum latency:
  - Zero bypass: accept in cycle T, res_valid in T+1.
  - Normal: accept in T, div_start in T+1, res_valid in the cycle after div_done.
- Back-to-back: the cycle after consumption, state is IDLE and req_valid belongs to the next instruction. No dead cycle is required beyond IDLE.
- Watchdog: the counter clears on entering LAUNCH and increments each cycle in RUN or DRAIN. When it reaches TIMEOUT: set err_timeout (sticky until rst), go to IDLE, and emit no res_valid.
- Operand and result registers change only at accept and capture respectively. A div_done in IDLE or DONE is ignored.

Test Plan:
- DIV signed a=-7 (32'hFFFFFFF9), b=2, divider model latency 34 -> one div_start pulse; stall_o high throughout; res_valid once; res_lo=32'hFFFFFFFD, res_hi=32'hFFFFFFFF.
- DIVU a=100, b=0, BYPASS_ZERO=1 -> no div_start; res_valid at T+1; res_hi=100, res_lo=32'hFFFFFFFF.
- DIVU 100/7 with pipe_hold high for 5 cycles after div_done -> stall_o drops with res_valid only when pipe_hold falls; res_lo=14, res_hi=2 held stable.
- flush 10 cycles into RUN, new DIVU 9/3 issued immediately -> DRAIN stalls the new request until the old div_done; old result never reaches res_valid; new result res_lo=3, res_hi=0.
- Two back-to-back DIVU (20/4 then 21/4), pipe_hold=0 -> two res_valid pulses, (lo,hi)=(5,0) then (5,1); second div_start two cycles after first res_valid.
- Divider model never asserts div_done -> err_timeout set TIMEOUT cycles after entering RUN; state IDLE; rst clears err_timeout.
